// File: rtl/ctrl_pkg.sv
// Shared types and constants for the DataPath hardwired control unit.
package ctrl_pkg;

  // IR field layout
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_LSB  = 15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T4W,
    ST_T5,
    ST_T6,
    ST_HALT
  } state_e;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd15;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'd16;
  localparam logic [OPC_W-1:0] OP_HALT = 5'd27;

  // Single-bit control strobes; register indices and ALU op travel separately.
  typedef struct packed {
    logic rf_out;
    logic pc_out;
    logic ir_out;
    logic ry_out;
    logic rzlo_out;
    logic rzhi_out;
    logic mar_out;
    logic rhi_out;
    logic rlo_out;
    logic mdr_out;
    logic rf_in;
    logic pc_in;
    logic ir_in;
    logic ry_in;
    logic rz_in;
    logic mar_in;
    logic rhi_in;
    logic rlo_in;
    logic mdr_in;
    logic start;
    logic read;
    logic inc_pc;
    logic halted;
  } ctrl_t;

  function automatic logic [2:0] alu_sel(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_ADD:  return 3'd0;
      OP_SUB:  return 3'd1;
      OP_AND:  return 3'd2;
      OP_OR:   return 3'd3;
      OP_MUL:  return 3'd4;
      OP_DIV:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_hilo(input logic [OPC_W-1:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

  function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) ||
           (opc == OP_OR)  || is_hilo(opc);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state/field decode into the DataPath control vector.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPSEL_W = 6,
  parameter int unsigned RFSEL_W = 4
) (
  input  state_e             state_i,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic [REG_W-1:0]   ra_i,
  input  logic [REG_W-1:0]   rb_i,
  input  logic [REG_W-1:0]   rc_i,
  output ctrl_t              ctrl_o,
  output logic [RFSEL_W-1:0] rfsel_o,
  output logic [OPSEL_W-1:0] opsel_o
);

  // Moore output table: every strobe defaults low and is raised per state.
  always_comb begin
    ctrl_o  = '0;
    rfsel_o = '0;
    opsel_o = '0;
    case (state_i)
      ST_T0: begin
        ctrl_o.pc_out = 1'b1;
        ctrl_o.mar_in = 1'b1;
        ctrl_o.inc_pc = 1'b1;
        ctrl_o.rz_in  = 1'b1;
      end
      ST_T1: begin
        ctrl_o.rzlo_out = 1'b1;
        ctrl_o.pc_in    = 1'b1;
        ctrl_o.read     = 1'b1;
        ctrl_o.mdr_in   = 1'b1;
      end
      ST_T2: begin
        ctrl_o.mdr_out = 1'b1;
        ctrl_o.ir_in   = 1'b1;
      end
      ST_T3: begin
        ctrl_o.rf_out = 1'b1;
        ctrl_o.ry_in  = 1'b1;
        rfsel_o       = RFSEL_W'(rb_i);
      end
      ST_T4, ST_T4W: begin
        ctrl_o.rf_out = 1'b1;
        ctrl_o.rz_in  = 1'b1;
        ctrl_o.start  = (state_i == ST_T4);
        rfsel_o       = RFSEL_W'(rc_i);
        opsel_o       = OPSEL_W'(alu_sel(opcode_i));
      end
      ST_T5: begin
        ctrl_o.rzlo_out = 1'b1;
        if (is_hilo(opcode_i)) begin
          ctrl_o.rlo_in = 1'b1;
        end else begin
          ctrl_o.rf_in = 1'b1;
          rfsel_o      = RFSEL_W'(ra_i);
        end
      end
      ST_T6: begin
        ctrl_o.rzhi_out = 1'b1;
        ctrl_o.rhi_in   = 1'b1;
      end
      ST_HALT: begin
        ctrl_o.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired T0..T6 sequencer for DataPath register-register ALU instructions.
// Optional build macro: SINGLE_STEP_EN (adds the step input; one instruction per step edge).
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned OPSEL_W      = 6,
  parameter int unsigned RFSEL_W      = 4,
  parameter int unsigned ALU_WAIT_MAX = 63
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic               run,
  input  logic [31:0]        IRq,
  input  logic               finished,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               RFout,
  output logic               PCout,
  output logic               IRout,
  output logic               RYout,
  output logic               RZLOout,
  output logic               RZHIout,
  output logic               MARout,
  output logic               RHIout,
  output logic               RLOout,
  output logic               MDRout,
  output logic               RFin,
  output logic               PCin,
  output logic               IRin,
  output logic               RYin,
  output logic               RZin,
  output logic               MARin,
  output logic               RHIin,
  output logic               RLOin,
  output logic               MDRin,
  output logic [RFSEL_W-1:0] RFSelect,
  output logic [OPSEL_W-1:0] opSelect,
  output logic               start,
  output logic               Read,
  output logic               IncPC,
  output logic               halted,
  output logic               fault
);

  localparam int unsigned CNT_W = $clog2(ALU_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [REG_W-1:0] ra_q, ra_d;
  logic [REG_W-1:0] rc_q, rc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic [OPC_W-1:0] ir_opc;
  logic [REG_W-1:0] ir_ra, ir_rb, ir_rc;
  logic             unused_ir;

  assign ir_opc    = IRq[OPC_LSB +: OPC_W];
  assign ir_ra     = IRq[RA_LSB +: REG_W];
  assign ir_rb     = IRq[RB_LSB +: REG_W];
  assign ir_rc     = IRq[RC_LSB +: REG_W];
  assign unused_ir = ^IRq[RC_LSB-1:0];

  logic   fetch_go;
  state_e after_instr;

`ifdef SINGLE_STEP_EN
  logic step_q;

  // Previous step level for rising-edge detection.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign fetch_go    = run & step & ~step_q;
  assign after_instr = ST_IDLE;
`else
  assign fetch_go    = run;
  assign after_instr = run ? ST_T0 : ST_IDLE;
`endif

  // State, latched IR fields, ALU wait counter and sticky fault.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
      ra_q    <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      ra_q    <= ra_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: decode in T3, ALU wait/timeout in T4W.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    ra_d    = ra_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: if (fetch_go) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        opc_d = ir_opc;
        ra_d  = ir_ra;
        rc_d  = ir_rc;
        if (ir_opc == OP_HALT) begin
          state_d = ST_HALT;
        end else if (!is_alu_op(ir_opc)) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_T4;
        end
      end
      ST_T4: begin
        cnt_d   = '0;
        state_d = ST_T4W;
      end
      ST_T4W: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (finished) begin
          state_d = ST_T5;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_T5:   state_d = is_hilo(opc_q) ? ST_T6 : after_instr;
      ST_T6:   state_d = after_instr;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // IR is loaded at the T2->T3 edge, so T3 reads Rb straight from IRq;
  // later states use the fields latched on leaving T3.
  logic [REG_W-1:0] dec_opc_unused;
  assign dec_opc_unused = '0;

  ctrl_t ctrl;

  ctrl_decode #(
    .OPSEL_W (OPSEL_W),
    .RFSEL_W (RFSEL_W)
  ) u_decode (
    .state_i  (state_q),
    .opcode_i (opc_q),
    .ra_i     (ra_q),
    .rb_i     (ir_rb),
    .rc_i     (rc_q),
    .ctrl_o   (ctrl),
    .rfsel_o  (RFSelect),
    .opsel_o  (opSelect)
  );

  assign RFout   = ctrl.rf_out;
  assign PCout   = ctrl.pc_out;
  assign IRout   = ctrl.ir_out;
  assign RYout   = ctrl.ry_out;
  assign RZLOout = ctrl.rzlo_out;
  assign RZHIout = ctrl.rzhi_out;
  assign MARout  = ctrl.mar_out;
  assign RHIout  = ctrl.rhi_out;
  assign RLOout  = ctrl.rlo_out;
  assign MDRout  = ctrl.mdr_out;
  assign RFin    = ctrl.rf_in;
  assign PCin    = ctrl.pc_in;
  assign IRin    = ctrl.ir_in;
  assign RYin    = ctrl.ry_in;
  assign RZin    = ctrl.rz_in;
  assign MARin   = ctrl.mar_in;
  assign RHIin   = ctrl.rhi_in;
  assign RLOin   = ctrl.rlo_in;
  assign MDRin   = ctrl.mdr_in;
  assign start   = ctrl.start;
  assign Read    = ctrl.read;
  assign IncPC   = ctrl.inc_pc;
  assign halted  = ctrl.halted;
  assign fault   = fault_q;

  logic [9:0] bus_drv;
  assign bus_drv = {RFout, PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout, MDRout};

  a_bus_onehot: assert property (@(posedge Clock) disable iff (clear) $onehot0(bus_drv));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer (default build, no single-step).
module tb_ctrl_sequencer;

  logic        Clock = 1'b0;
  logic        clear, run, finished;
  logic [31:0] IRq;
  logic RFout, PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout, MDRout;
  logic RFin, PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, MDRin;
  logic [3:0] RFSelect;
  logic [5:0] opSelect;
  logic start, Read, IncPC, halted, fault;

  always #5 Clock = ~Clock;

  ctrl_sequencer #(
    .OPSEL_W      (6),
    .RFSEL_W      (4),
    .ALU_WAIT_MAX (63)
  ) dut (
    .Clock(Clock), .clear(clear), .run(run), .IRq(IRq), .finished(finished),
    .RFout(RFout), .PCout(PCout), .IRout(IRout), .RYout(RYout), .RZLOout(RZLOout),
    .RZHIout(RZHIout), .MARout(MARout), .RHIout(RHIout), .RLOout(RLOout), .MDRout(MDRout),
    .RFin(RFin), .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
    .RHIin(RHIin), .RLOin(RLOin), .MDRin(MDRin), .RFSelect(RFSelect), .opSelect(opSelect),
    .start(start), .Read(Read), .IncPC(IncPC), .halted(halted), .fault(fault)
  );

  typedef struct packed {
    logic [9:0] bus;
    logic [8:0] ld;
    logic [3:0] rfsel;
    logic [5:0] opsel;
    logic       start, read, incpc, halted, fault;
  } obs_t;

  typedef struct {
    logic        run, fin;
    logic [31:0] ir;
    obs_t        exp;
  } step_t;

  // bus order: RF PC IR RY RZLO RZHI MAR RHI RLO MDR
  localparam logic [9:0] B_NONE = 10'b0000000000;
  localparam logic [9:0] B_RF   = 10'b1000000000;
  localparam logic [9:0] B_PC   = 10'b0100000000;
  localparam logic [9:0] B_RZLO = 10'b0000100000;
  localparam logic [9:0] B_RZHI = 10'b0000010000;
  localparam logic [9:0] B_MDR  = 10'b0000000001;
  // load order: RF PC IR RY RZ MAR RHI RLO MDR
  localparam logic [8:0] L_NONE = 9'b000000000;
  localparam logic [8:0] L_RF   = 9'b100000000;
  localparam logic [8:0] L_PC   = 9'b010000000;
  localparam logic [8:0] L_IR   = 9'b001000000;
  localparam logic [8:0] L_RY   = 9'b000100000;
  localparam logic [8:0] L_RZ   = 9'b000010000;
  localparam logic [8:0] L_MAR  = 9'b000001000;
  localparam logic [8:0] L_RHI  = 9'b000000100;
  localparam logic [8:0] L_RLO  = 9'b000000010;
  localparam logic [8:0] L_MDR  = 9'b000000001;

  step_t scen[$];
  obs_t  expq[$];
  obs_t  log_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    m_fault = 1'b0;

  function automatic obs_t dut_obs();
    obs_t o;
    o.bus    = {RFout, PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout, MDRout};
    o.ld     = {RFin, PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, MDRin};
    o.rfsel  = RFSelect;
    o.opsel  = opSelect;
    o.start  = start;
    o.read   = Read;
    o.incpc  = IncPC;
    o.halted = halted;
    o.fault  = fault;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got bus=%b ld=%b rfsel=%0d opsel=%0d start=%b read=%b inc=%b halted=%b fault=%b, expected bus=%b ld=%b rfsel=%0d opsel=%0d start=%b read=%b inc=%b halted=%b fault=%b",
               name, a.bus, a.ld, a.rfsel, a.opsel, a.start, a.read, a.incpc, a.halted, a.fault,
               e.bus, e.ld, e.rfsel, e.opsel, e.start, e.read, e.incpc, e.halted, e.fault);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Opcode to ALU select from the instruction set table; -1 = not an ALU op.
  function automatic int op_table(input int opc);
    case (opc)
      3: return 0;
      4: return 1;
      5: return 2;
      6: return 3;
      15: return 4;
      16: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic obs_t mk(input logic [9:0] b, input logic [8:0] l, input int rs, input int os,
                              input bit st, input bit rd, input bit inc, input bit h);
    obs_t o;
    o.bus = b; o.ld = l; o.rfsel = 4'(rs); o.opsel = 6'(os);
    o.start = st; o.read = rd; o.incpc = inc; o.halted = h; o.fault = m_fault;
    return o;
  endfunction

  task automatic add_cycle(input logic r, input logic f, input logic [31:0] ir, input obs_t e);
    step_t s;
    s.run = r; s.fin = f; s.ir = ir; s.exp = e;
    scen.push_back(s);
  endtask

  task automatic add_idle(input int n, input logic r, input logic [31:0] ir);
    for (int i = 0; i < n; i++) add_cycle(r, 1'b0, ir, mk(B_NONE, L_NONE, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic add_halt(input int n, input logic [31:0] ir);
    for (int i = 0; i < n; i++) add_cycle(1'b1, 1'b0, ir, mk(B_NONE, L_NONE, 0, 0, 0, 0, 0, 1));
  endtask

  // Expected cycle trace of one instruction starting in T0. d = cycle in the ALU
  // wait at which finished rises (0 = never). run_end = run level from T2 onward.
  task automatic add_instr(input logic [31:0] ir, input int d, input logic run_end);
    int opc, ra, rb, rc, sel;
    bit hilo;
    opc = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    sel = op_table(opc);
    hilo = (opc == 15) || (opc == 16);
    add_cycle(1'b1, 1'b0, ir, mk(B_PC, L_MAR | L_RZ, 0, 0, 0, 0, 1, 0));
    add_cycle(1'b1, 1'b0, ir, mk(B_RZLO, L_PC | L_MDR, 0, 0, 0, 1, 0, 0));
    add_cycle(run_end, 1'b0, ir, mk(B_MDR, L_IR, 0, 0, 0, 0, 0, 0));
    add_cycle(run_end, 1'b0, ir, mk(B_RF, L_RY, rb, 0, 0, 0, 0, 0));
    if (opc == 27) begin
      add_halt(4, ir);
      return;
    end
    if (sel < 0) begin
      m_fault = 1'b1;
      add_halt(4, ir);
      return;
    end
    add_cycle(run_end, 1'b0, ir, mk(B_RF, L_RZ, rc, sel, 1, 0, 0, 0));
    if (d == 0) begin
      for (int k = 1; k <= 63; k++) add_cycle(run_end, 1'b0, ir, mk(B_RF, L_RZ, rc, sel, 0, 0, 0, 0));
      m_fault = 1'b1;
      add_halt(4, ir);
      return;
    end
    for (int k = 1; k <= d; k++) add_cycle(run_end, logic'(k == d), ir, mk(B_RF, L_RZ, rc, sel, 0, 0, 0, 0));
    if (hilo) begin
      add_cycle(run_end, 1'b0, ir, mk(B_RZLO, L_RLO, 0, 0, 0, 0, 0, 0));
      add_cycle(run_end, 1'b0, ir, mk(B_RZHI, L_RHI, 0, 0, 0, 0, 0, 0));
    end else begin
      add_cycle(run_end, 1'b0, ir, mk(B_RZLO, L_RF, ra, 0, 0, 0, 0, 0));
    end
  endtask

  // Drives the scenario one cycle at a time; the compare process consumes expq.
  task automatic play();
    step_t s;
    log_q.delete();
    while (scen.size() > 0) begin
      s = scen.pop_front();
      run = s.run; finished = s.fin; IRq = s.ir;
      expq.push_back(s.exp);
      @(posedge Clock); #1;
    end
  endtask

  // Asynchronous clear mid-cycle; outputs must drop before the next edge.
  task automatic do_clear(input string name);
    #2 clear = 1'b1;
    #1 check_obs(name, dut_obs(), '0);
    m_fault = 1'b0;
    run = 1'b0; finished = 1'b0;
    #2 clear = 1'b0;
    @(posedge Clock); #1;
  endtask

  function automatic int first_idx(input logic [9:0] b);
    for (int i = 0; i < log_q.size(); i++) if (log_q[i].bus == b) return i;
    return -1;
  endfunction

  function automatic int instr_len();
    int f, l;
    f = first_idx(B_PC);
    l = -1;
    for (int i = 0; i < log_q.size(); i++) if ((log_q[i].ld & (L_RF | L_RHI)) != 0) l = i;
    if (f < 0 || l < 0) return -1;
    return l - f + 1;
  endfunction

  function automatic int count_start();
    int n = 0;
    for (int i = 0; i < log_q.size(); i++) if (log_q[i].start) n++;
    return n;
  endfunction

  function automatic int count_rfin();
    int n = 0;
    for (int i = 0; i < log_q.size(); i++) if (log_q[i].ld[8]) n++;
    return n;
  endfunction

  // Compare process: one model entry per cycle, sampled on the falling edge.
  always @(negedge Clock) begin
    obs_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = dut_obs();
      log_q.push_back(a);
      check_obs($sformatf("cycle%0d", cyc), a, e);
      cyc++;
    end
  end

  localparam logic [31:0] I_AND  = 32'h2891_8000;
  localparam logic [31:0] I_ADD  = 32'h1891_8000;
  localparam logic [31:0] I_OR   = 32'h3091_8000;
  localparam logic [31:0] I_MUL  = 32'h7891_8000;
  localparam logic [31:0] I_DIV  = 32'h8091_8000;
  localparam logic [31:0] I_ILL  = 32'hF891_8000;
  localparam logic [31:0] I_HALT = 32'hD891_8000;

  initial begin
    clear = 1'b1; run = 1'b0; finished = 1'b0; IRq = '0;
    #12 check_obs("reset", dut_obs(), '0);
    #1 clear = 1'b0;
    @(posedge Clock); #1;

    // AND Ra=1 Rb=2 Rc=3, finished on the first wait cycle
    add_idle(1, 1'b1, I_AND); add_instr(I_AND, 1, 1'b0); add_idle(3, 1'b0, I_AND);
    play();
    check_val("and_t3_rfsel", int'(log_q[4].rfsel), 2);
    check_val("and_t3_strobes", int'({log_q[4].bus, log_q[4].ld}), int'({B_RF, L_RY}));
    check_val("and_t4_rfsel", int'(log_q[5].rfsel), 3);
    check_val("and_t4_opsel", int'(log_q[5].opsel), 2);
    check_val("and_start_pulses", count_start(), 1);
    check_val("and_t5_rfsel", int'(log_q[7].rfsel), 1);
    check_val("and_t5_strobes", int'({log_q[7].bus, log_q[7].ld}), int'({B_RZLO, L_RF}));
    check_val("and_cycles", instr_len(), 7);

    // MUL with finished after 5 wait cycles
    add_idle(1, 1'b1, I_MUL); add_instr(I_MUL, 5, 1'b0); add_idle(2, 1'b0, I_MUL);
    play();
    check_val("mul_t5_strobes", int'({log_q[11].bus, log_q[11].ld}), int'({B_RZLO, L_RLO}));
    check_val("mul_t6_strobes", int'({log_q[12].bus, log_q[12].ld}), int'({B_RZHI, L_RHI}));
    check_val("mul_rfin_count", count_rfin(), 0);
    check_val("mul_cycles", instr_len(), 12);

    // MUL immediate finished: 8-cycle instruction
    add_idle(1, 1'b1, I_MUL); add_instr(I_MUL, 1, 1'b0); add_idle(1, 1'b0, I_MUL);
    play();
    check_val("mul_fast_cycles", instr_len(), 8);

    // Back-to-back ADD then DIV with run held, then run dropped during T2 of ADD
    add_idle(1, 1'b1, I_ADD); add_instr(I_ADD, 1, 1'b1); add_instr(I_DIV, 3, 1'b0);
    add_idle(1, 1'b1, I_ADD); add_instr(I_ADD, 2, 1'b0); add_idle(5, 1'b0, I_ADD);
    play();

    // finished on the very last allowed wait cycle wins over timeout
    add_idle(1, 1'b1, I_OR); add_instr(I_OR, 63, 1'b0); add_idle(2, 1'b0, I_OR);
    play();
    check_val("late_finish_fault", int'(fault), 0);

    // clear in the middle of the ALU wait
    add_idle(1, 1'b1, I_ADD); add_instr(I_ADD, 40, 1'b0);
    while (scen.size() > 9) scen.pop_back();
    play();
    do_clear("clear_mid_t4w");
    add_idle(2, 1'b0, I_ADD);
    play();

    // ALU timeout: halted with fault after 63 wait cycles, stays halted with run=1
    add_idle(1, 1'b1, I_ADD); add_instr(I_ADD, 0, 1'b0);
    play();
    check_val("timeout_fault_before", int'(log_q[68].fault), 0);
    check_val("timeout_halt_cycle", int'(log_q[69].halted), 1);
    check_val("timeout_fault_after", int'(log_q[69].fault), 1);
    do_clear("clear_after_timeout");

    // illegal opcode 31
    add_idle(1, 1'b1, I_ILL); add_instr(I_ILL, 1, 1'b0);
    play();
    check_val("illegal_start_pulses", count_start(), 0);
    check_val("illegal_fault", int'(log_q[5].fault), 1);
    do_clear("clear_after_illegal");

    // HALT opcode: halted without fault
    add_idle(1, 1'b1, I_HALT); add_instr(I_HALT, 1, 1'b0);
    play();
    check_val("halt_op_halted", int'(log_q[5].halted), 1);
    check_val("halt_op_fault", int'(log_q[5].fault), 0);
    do_clear("clear_after_halt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
